// File: rtl/alu_arbiter_n.sv
// Shares one ALU between the CPU datapath and NUM_UNITS multi-cycle coprocessor
// FSMs, freezing the PC while a unit owns the ALU and aborting hung units.
module alu_arbiter_n #(
  parameter int DATA_W    = 16,
  parameter int OP_W      = 6,
  parameter int FLAG_W    = 4,
  parameter int NUM_UNITS = 2,
  parameter int TIMEOUT   = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cpu_active,
  input  logic [OP_W-1:0]             cpu_alu_op,
  input  logic [DATA_W-1:0]           cpu_alu_x,
  input  logic [DATA_W-1:0]           cpu_alu_y,
  input  logic [NUM_UNITS-1:0]        unit_trig,
  input  logic [NUM_UNITS-1:0]        unit_req_alu,
  input  logic [NUM_UNITS*OP_W-1:0]   unit_alu_op,
  input  logic [NUM_UNITS*DATA_W-1:0] unit_alu_x,
  input  logic [NUM_UNITS*DATA_W-1:0] unit_alu_y,
  input  logic [NUM_UNITS-1:0]        unit_done,
  input  logic [DATA_W-1:0]           alu_result,
  input  logic [FLAG_W-1:0]           alu_flags,
  output logic [OP_W-1:0]             alu_opcode,
  output logic [DATA_W-1:0]           alu_x_in,
  output logic [DATA_W-1:0]           alu_y_in,
  output logic                        stall,
  output logic [NUM_UNITS-1:0]        unit_start,
  output logic [NUM_UNITS-1:0]        unit_abort,
  output logic [NUM_UNITS-1:0]        unit_grant,
  output logic [DATA_W-1:0]           unit_alu_result,
  output logic [DATA_W-1:0]           cpu_alu_result,
  output logic [FLAG_W-1:0]           cpu_alu_flags,
  output logic                        busy,
  output logic                        timeout_err,
  output logic [2:0]                  owner
);

  // A zero-width counter is illegal, so a disabled watchdog keeps one dummy bit.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int LAST  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state;
  logic [2:0]         owner_q;
  logic [CNT_W-1:0]   count;
  logic               err_q;

  logic               trig_hit;
  logic [2:0]         trig_idx;
  logic [NUM_UNITS-1:0] trig_onehot;
  logic               owner_ok;
  logic [NUM_UNITS-1:0] owner_sel;
  logic               own_req;
  logic               own_done;
  logic [OP_W-1:0]    own_op;
  logic [DATA_W-1:0]  own_x;
  logic [DATA_W-1:0]  own_y;
  logic               timeout_hit;

  // Trigger priority and owner-side muxing.
  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    trig_hit    = |unit_trig;
    trig_idx    = '0;
    trig_onehot = unit_trig & (~unit_trig + NUM_UNITS'(1));
    for (int k = NUM_UNITS - 1; k >= 0; k--) begin
      if (unit_trig[k]) trig_idx = 3'(k);
    end

    owner_ok  = int'(owner_q) < NUM_UNITS;
    owner_sel = '0;
    own_req   = 1'b0;
    own_done  = 1'b0;
    own_op    = '0;
    own_x     = '0;
    own_y     = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      if (owner_q == 3'(k)) begin
        owner_sel[k] = 1'b1;
        own_req      = unit_req_alu[k];
        own_done     = unit_done[k];
        own_op       = unit_alu_op[k*OP_W +: OP_W];
        own_x        = unit_alu_x[k*DATA_W +: DATA_W];
        own_y        = unit_alu_y[k*DATA_W +: DATA_W];
      end
    end

    timeout_hit = (TIMEOUT != 0) && (count == CNT_W'(LAST));
  end

  // Output decode; reset forces every combinational output low.
  always_comb begin
    alu_opcode      = '0;
    alu_x_in        = '0;
    alu_y_in        = '0;
    stall           = 1'b0;
    unit_start      = '0;
    unit_abort      = '0;
    unit_grant      = '0;
    unit_alu_result = '0;
    cpu_alu_result  = '0;
    cpu_alu_flags   = '0;
    busy            = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (trig_hit) begin
            stall      = 1'b1;
            unit_start = trig_onehot;
          end else if (cpu_active) begin
            alu_opcode     = cpu_alu_op;
            alu_x_in       = cpu_alu_x;
            alu_y_in       = cpu_alu_y;
            cpu_alu_result = alu_result;
            cpu_alu_flags  = alu_flags;
          end
        end
        BUSY: begin
          busy = 1'b1;
          if (owner_ok) begin
            stall = 1'b1;
            if (own_req) begin
              alu_opcode      = own_op;
              alu_x_in        = own_x;
              alu_y_in        = own_y;
              unit_grant      = owner_sel;
              unit_alu_result = alu_result;
            end
            // Done beats a coinciding timeout.
            if (own_done) begin
              stall = 1'b0;
            end else if (timeout_hit) begin
              stall      = 1'b0;
              unit_abort = owner_sel;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      owner_q <= '0;
      count   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (trig_hit) begin
            owner_q <= trig_idx;
            count   <= '0;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (!owner_ok || own_done) begin
            state <= IDLE;
          end else if (timeout_hit) begin
            err_q <= 1'b1;
            state <= IDLE;
          end else if (count != '1) begin
            count <= count + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign owner       = owner_q;
  assign timeout_err = err_q;

endmodule
